uart_rx_deframer: RTL and testbench

//  Sits directly downstream of uart_rx. Consumes its byte stream (byte/valid/error pulses) and

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_pkt_buf.sv | 29 ++
 rtl/uart_rx_deframer.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART frame deframer: FSM states, abort causes and the
// default start-of-frame marker.
package uart_pkg;

   typedef enum logic [2:0] {
      S_SYNC    = 3'd0,
      S_LEN     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CHK     = 3'd3,
      S_DRAIN   = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      ERR_NONE = 3'd0,
      ERR_PAR  = 3'd1,
      ERR_LEN  = 3'd2,
      ERR_CHK  = 3'd3,
      ERR_TMO  = 3'd4,
      ERR_OVR  = 3'd5
   } err_code_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   // Running frame checksum: XOR of LEN and every payload byte.
   function automatic logic [7:0] chk_fold(input logic [7:0] chk, input logic [7:0] data);
      return chk ^ data;
   endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store for one frame: single write port, asynchronous read port.
// Storage is deliberately not reset; pointers in the deframer define validity.
module uart_pkt_buf
   import uart_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Capture payload bytes as they arrive.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_rx_deframer.sv
// Assembles SYNC/LEN/payload/CHK frames from the uart_rx byte stream and
// releases the payload on a valid/ready stream only once the checksum matches.
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int                DATA_W        = 8,
   parameter int                MAX_LEN       = 16,
   parameter logic [DATA_W-1:0] SYNC_BYTE     = SYNC_DEFAULT,
   parameter int                TIMEOUT_TICKS = 1024
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              tick_i,
   input  logic [DATA_W-1:0] rxd_byte_i,
   input  logic              rxd_vld_i,
   input  logic              rxd_err_i,
   output logic [DATA_W-1:0] pkt_byte_o,
   output logic              pkt_vld_o,
   output logic              pkt_last_o,
   input  logic              pkt_rdy_i,
   output logic              frame_ok_o,
   output logic              frame_err_o,
   output logic [2:0]        err_code_o,
   output logic [15:0]       frame_cnt_o,
   output logic [2:0]        fsm_state_o
);

   localparam int LEN_W  = $clog2(MAX_LEN + 1);
   localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TMO_W  = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [DATA_W-1:0] MAX_LEN_B = DATA_W'(MAX_LEN);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_TICKS - 1);

   state_t            state;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  wr_ptr;
   logic [LEN_W-1:0]  rd_ptr;
   logic [DATA_W-1:0] chk;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [DATA_W-1:0] rd_data;
   logic              byte_ev;
   logic              any_ev;
   logic              timed;
   logic              tmo_hit;
   logic              buf_we;
   logic              abort;
   err_code_t         abort_code;

   // An error pulse overrides a simultaneous byte pulse.
   assign byte_ev     = rxd_vld_i & ~rxd_err_i;
   assign any_ev      = rxd_vld_i | rxd_err_i;
   assign timed       = (state == S_LEN) | (state == S_PAYLOAD) | (state == S_CHK);
   assign tmo_hit     = timed & tick_i & ~any_ev & (tmo_cnt == TMO_LAST);
   assign buf_we      = (state == S_PAYLOAD) & byte_ev;
   assign fsm_state_o = state;

   uart_pkt_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (MAX_LEN),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk_i   (clk_i),
      .we_i    (buf_we),
      .waddr_i (wr_ptr[ADDR_W-1:0]),
      .wdata_i (rxd_byte_i),
      .raddr_i (rd_ptr[ADDR_W-1:0]),
      .rdata_o (rd_data)
   );

   // Decide whether this cycle aborts the frame in progress, and why.
   always_comb begin
      abort      = 1'b0;
      abort_code = ERR_NONE;
      case (state)
         S_LEN: begin
            if (rxd_err_i) begin
               abort = 1'b1; abort_code = ERR_PAR;
            end else if (rxd_vld_i && ((rxd_byte_i == DATA_W'(0)) || (rxd_byte_i > MAX_LEN_B))) begin
               abort = 1'b1; abort_code = ERR_LEN;
            end else if (tmo_hit) begin
               abort = 1'b1; abort_code = ERR_TMO;
            end else begin
               abort = 1'b0; abort_code = ERR_NONE;
            end
         end
         S_PAYLOAD: begin
            if (rxd_err_i) begin
               abort = 1'b1; abort_code = ERR_PAR;
            end else if (tmo_hit) begin
               abort = 1'b1; abort_code = ERR_TMO;
            end else begin
               abort = 1'b0; abort_code = ERR_NONE;
            end
         end
         S_CHK: begin
            if (rxd_err_i) begin
               abort = 1'b1; abort_code = ERR_PAR;
            end else if (rxd_vld_i && (rxd_byte_i != chk)) begin
               abort = 1'b1; abort_code = ERR_CHK;
            end else if (tmo_hit) begin
               abort = 1'b1; abort_code = ERR_TMO;
            end else begin
               abort = 1'b0; abort_code = ERR_NONE;
            end
         end
         S_DRAIN: begin
            if (any_ev) begin
               abort = 1'b1; abort_code = ERR_OVR;
            end else begin
               abort = 1'b0; abort_code = ERR_NONE;
            end
         end
         default: begin
            abort      = 1'b0;
            abort_code = ERR_NONE;
         end
      endcase
   end

   // Frame FSM, pointers, checksum, timeout and all registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= S_SYNC;
         len         <= LEN_W'(0);
         wr_ptr      <= LEN_W'(0);
         rd_ptr      <= LEN_W'(0);
         chk         <= DATA_W'(0);
         tmo_cnt     <= TMO_W'(0);
         pkt_byte_o  <= DATA_W'(0);
         pkt_vld_o   <= 1'b0;
         pkt_last_o  <= 1'b0;
         frame_ok_o  <= 1'b0;
         frame_err_o <= 1'b0;
         err_code_o  <= 3'd0;
         frame_cnt_o <= 16'd0;
      end else begin
         frame_ok_o  <= 1'b0;
         frame_err_o <= 1'b0;
         if (abort) begin
            frame_err_o <= 1'b1;
            err_code_o  <= abort_code;
         end
         if (any_ev || !timed) begin
            tmo_cnt <= TMO_W'(0);
         end else if (tick_i) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end
         case (state)
            S_SYNC: begin
               if (byte_ev && (rxd_byte_i == SYNC_BYTE)) begin
                  state <= S_LEN;
               end
            end
            S_LEN: begin
               if (abort) begin
                  state <= S_SYNC;
               end else if (byte_ev) begin
                  len    <= rxd_byte_i[LEN_W-1:0];
                  chk    <= rxd_byte_i;
                  wr_ptr <= LEN_W'(0);
                  state  <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (abort) begin
                  state <= S_SYNC;
               end else if (byte_ev) begin
                  chk    <= chk_fold(chk, rxd_byte_i);
                  wr_ptr <= wr_ptr + LEN_W'(1);
                  if ((wr_ptr + LEN_W'(1)) == len) begin
                     state <= S_CHK;
                  end
               end
            end
            S_CHK: begin
               if (abort) begin
                  state <= S_SYNC;
               end else if (byte_ev) begin
                  // rd_ptr is 0 here, so rd_data already presents payload byte 0.
                  frame_ok_o  <= 1'b1;
                  frame_cnt_o <= frame_cnt_o + 16'd1;
                  pkt_vld_o   <= 1'b1;
                  pkt_byte_o  <= rd_data;
                  pkt_last_o  <= (len == LEN_W'(1));
                  rd_ptr      <= LEN_W'(1);
                  state       <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pkt_vld_o && pkt_rdy_i) begin
                  if (pkt_last_o) begin
                     pkt_vld_o  <= 1'b0;
                     pkt_last_o <= 1'b0;
                     rd_ptr     <= LEN_W'(0);
                     state      <= S_SYNC;
                  end else begin
                     pkt_byte_o <= rd_data;
                     pkt_last_o <= (rd_ptr == (len - LEN_W'(1)));
                     rd_ptr     <= rd_ptr + LEN_W'(1);
                  end
               end
            end
            default: begin
               state <= S_SYNC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomised self-checking bench for uart_rx_deframer against a frame-level
// reference model (parse SYNC/LEN/payload/CHK and predict outcome and payload).
module tb_uart_rx_deframer;

   localparam int MAX_LEN = 16;
   localparam int TMO     = 1024;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        tick = 1'b0;
   logic [7:0]  rxd_byte = 8'h00;
   logic        rxd_vld = 1'b0;
   logic        rxd_err = 1'b0;
   logic        pkt_rdy = 1'b1;
   logic [7:0]  pkt_byte;
   logic        pkt_vld;
   logic        pkt_last;
   logic        frame_ok;
   logic        frame_err;
   logic [2:0]  err_code;
   logic [15:0] frame_cnt;
   logic [2:0]  fsm_state;

   always #5 clk = ~clk;

   uart_rx_deframer #(
      .DATA_W(8), .MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT_TICKS(TMO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .tick_i(tick),
      .rxd_byte_i(rxd_byte), .rxd_vld_i(rxd_vld), .rxd_err_i(rxd_err),
      .pkt_byte_o(pkt_byte), .pkt_vld_o(pkt_vld), .pkt_last_o(pkt_last),
      .pkt_rdy_i(pkt_rdy), .frame_ok_o(frame_ok), .frame_err_o(frame_err),
      .err_code_o(err_code), .frame_cnt_o(frame_cnt), .fsm_state_o(fsm_state)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          ok_cnt = 0;
   int          err_cnt = 0;
   int          both_cnt = 0;
   logic [2:0]  last_code = 3'd0;
   logic [7:0]  out_q[$];
   bit          last_q[$];
   logic [7:0]  tx_q[$];
   logic [7:0]  exp_pl[$];
   bit          exp_ok;
   logic [2:0]  exp_code;
   logic [15:0] exp_cnt = 16'd0;

   // Observe outputs mid-cycle: pulses, error codes and accepted payload bytes.
   always @(negedge clk) begin
      if (frame_ok) ok_cnt++;
      if (frame_err) begin
         err_cnt++;
         last_code = err_code;
      end
      if (frame_ok && frame_err) both_cnt++;
      if (pkt_vld && pkt_rdy) begin
         out_q.push_back(pkt_byte);
         last_q.push_back(pkt_last);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rxd_byte = b; rxd_vld = 1'b1;
      @(posedge clk); #1;
      rxd_vld = 1'b0; rxd_byte = 8'h00;
   endtask

   task automatic send_err();
      rxd_err = 1'b1;
      @(posedge clk); #1;
      rxd_err = 1'b0;
   endtask

   task automatic send_tx(input int max_gap);
      foreach (tx_q[i]) begin
         send_byte(tx_q[i]);
         idle($urandom_range(0, max_gap));
      end
   endtask

   // Reference model: interpret tx_q as one frame and predict its outcome.
   task automatic model_frame();
      int         l;
      logic [7:0] x;
      exp_pl.delete();
      l = int'(tx_q[1]);
      if (l == 0 || l > MAX_LEN) begin
         exp_ok = 1'b0; exp_code = 3'd2;
      end else begin
         x = tx_q[1];
         for (int i = 0; i < l; i++) x = x ^ tx_q[2 + i];
         if (tx_q[2 + l] == x) begin
            exp_ok = 1'b1;
            for (int i = 0; i < l; i++) exp_pl.push_back(tx_q[2 + i]);
            exp_cnt = exp_cnt + 16'd1;
         end else begin
            exp_ok = 1'b0; exp_code = 3'd3;
         end
      end
   endtask

   task automatic drain(input int n, input bit rand_rdy, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (out_q.size() >= n) begin
            timed_out = 1'b0;
            break;
         end
         pkt_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
      end
      pkt_rdy = 1'b1;
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({pkt_byte, pkt_vld, pkt_last, frame_ok, frame_err, err_code, frame_cnt, fsm_state} !== 40'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got byte=%h vld=%b last=%b ok=%b err=%b code=%0d cnt=%0d st=%0d required all 0",
                  pkt_byte, pkt_vld, pkt_last, frame_ok, frame_err, err_code, frame_cnt, fsm_state);
      end
   endtask

   task automatic test_good_frame();
      int ok0, err0;
      out_q.delete(); last_q.delete();
      ok0 = ok_cnt; err0 = err_cnt;
      tx_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h31};
      model_frame();
      pkt_rdy = 1'b1;
      for (int i = 0; i < 4; i++) send_byte(tx_q[i]);
      send_byte(tx_q[4]);
      n_cmp++;
      if ({frame_ok, pkt_vld, pkt_byte, pkt_last} !== {1'b1, 1'b1, 8'h11, 1'b0}) begin
         n_bad++;
         $display("FAIL good_latency: got ok=%b vld=%b byte=%h last=%b required ok=1 vld=1 byte=11 last=0",
                  frame_ok, pkt_vld, pkt_byte, pkt_last);
      end
      idle(1);
      n_cmp++;
      if ({frame_ok, pkt_vld, pkt_byte, pkt_last} !== {1'b0, 1'b1, 8'h22, 1'b1}) begin
         n_bad++;
         $display("FAIL good_second: got ok=%b vld=%b byte=%h last=%b required ok=0 vld=1 byte=22 last=1",
                  frame_ok, pkt_vld, pkt_byte, pkt_last);
      end
      idle(1);
      n_cmp++;
      if (pkt_vld !== 1'b0) begin
         n_bad++; $display("FAIL good_end_vld: got %b required 0", pkt_vld);
      end
      n_cmp++;
      if ((ok_cnt - ok0) != 1 || (err_cnt - err0) != 0 || out_q.size() != 2) begin
         n_bad++;
         $display("FAIL good_counts: got ok=%0d err=%0d bytes=%0d required 1 0 2", ok_cnt - ok0, err_cnt - err0, out_q.size());
      end
      n_cmp++;
      if (frame_cnt !== exp_cnt) begin
         n_bad++; $display("FAIL good_frame_cnt: got %0d required %0d", frame_cnt, exp_cnt);
      end
   endtask

   task automatic test_bad_chk();
      int ok0, err0;
      out_q.delete();
      ok0 = ok_cnt; err0 = err_cnt;
      tx_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h30};
      send_tx(0);
      idle(3);
      n_cmp++;
      if ((err_cnt - err0) != 1 || last_code !== 3'd3 || out_q.size() != 0 || ok_cnt != ok0) begin
         n_bad++;
         $display("FAIL bad_chk: got errs=%0d code=%0d bytes=%0d oks=%0d required 1 3 0 0",
                  err_cnt - err0, last_code, out_q.size(), ok_cnt - ok0);
      end
      // A5 as a failing checksum must not start a new frame.
      ok0 = ok_cnt; err0 = err_cnt;
      tx_q = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'h02, 8'h11, 8'h22, 8'h31};
      send_tx(0);
      idle(4);
      n_cmp++;
      if ((err_cnt - err0) != 1 || (ok_cnt - ok0) != 0 || last_code !== 3'd3) begin
         n_bad++;
         $display("FAIL sync_not_reused: got errs=%0d oks=%0d code=%0d required 1 0 3", err_cnt - err0, ok_cnt - ok0, last_code);
      end
   endtask

   task automatic test_len_and_junk();
      int err0;
      err0 = err_cnt;
      tx_q = '{8'hA5, 8'h00};
      send_tx(1); idle(2);
      n_cmp++;
      if ((err_cnt - err0) != 1 || last_code !== 3'd2) begin
         n_bad++; $display("FAIL len_zero: got errs=%0d code=%0d required 1 2", err_cnt - err0, last_code);
      end
      err0 = err_cnt;
      tx_q = '{8'hA5, 8'h11};
      send_tx(1); idle(2);
      n_cmp++;
      if ((err_cnt - err0) != 1 || last_code !== 3'd2) begin
         n_bad++; $display("FAIL len_over: got errs=%0d code=%0d required 1 2", err_cnt - err0, last_code);
      end
      err0 = err_cnt;
      tx_q = '{8'h00, 8'hFF, 8'h3C};
      send_tx(1);
      send_err();
      rxd_byte = 8'hA5; rxd_vld = 1'b1; rxd_err = 1'b1;
      @(posedge clk); #1;
      rxd_vld = 1'b0; rxd_err = 1'b0;
      tx_q = '{8'h02, 8'h11, 8'h22, 8'h31};
      send_tx(0); idle(3);
      n_cmp++;
      if ((err_cnt - err0) != 0 || fsm_state !== 3'd0) begin
         n_bad++; $display("FAIL junk_ignored: got errs=%0d state=%0d required 0 0", err_cnt - err0, fsm_state);
      end
   endtask

   task automatic test_timeout_parity();
      tx_q = '{8'hA5, 8'h03, 8'h01};
      send_tx(0);
      tick = 1'b1;
      idle(TMO - 1);
      rxd_byte = 8'h02; rxd_vld = 1'b1;
      @(posedge clk); #1;
      rxd_vld = 1'b0;
      n_cmp++;
      if (frame_err !== 1'b0) begin
         n_bad++; $display("FAIL tmo_byte_wins: got frame_err=%b required 0", frame_err);
      end
      idle(TMO - 1);
      n_cmp++;
      if (frame_err !== 1'b0) begin
         n_bad++; $display("FAIL tmo_early: got frame_err=%b required 0", frame_err);
      end
      idle(1);
      tick = 1'b0;
      n_cmp++;
      if (frame_err !== 1'b1 || err_code !== 3'd4) begin
         n_bad++; $display("FAIL tmo_abort: got err=%b code=%0d required 1 4", frame_err, err_code);
      end
      idle(2);
      send_byte(8'hA5); send_byte(8'h03);
      send_err();
      n_cmp++;
      if (frame_err !== 1'b1 || err_code !== 3'd1) begin
         n_bad++; $display("FAIL parity_abort: got err=%b code=%0d required 1 1", frame_err, err_code);
      end
      idle(2);
   endtask

   task automatic test_overrun();
      int  unstable;
      bit  to;
      out_q.delete(); last_q.delete();
      unstable = 0;
      pkt_rdy = 1'b0;
      tx_q = '{8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h02 ^ 8'h5A ^ 8'hC3};
      model_frame();
      send_tx(0);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            send_byte(8'h77);
            n_cmp++;
            if (frame_err !== 1'b1 || err_code !== 3'd5) begin
               n_bad++; $display("FAIL overrun_err: got err=%b code=%0d required 1 5", frame_err, err_code);
            end
         end else begin
            idle(1);
         end
         if (pkt_byte !== exp_pl[0] || pkt_vld !== 1'b1) unstable++;
      end
      n_cmp++;
      if (unstable != 0) begin
         n_bad++; $display("FAIL stall_stable: got %0d unstable cycles required 0", unstable);
      end
      drain(2, 1'b0, to);
      idle(1);
      n_cmp++;
      if (to || out_q.size() != 2 || out_q[0] !== exp_pl[0] || out_q[1] !== exp_pl[1] || last_q[0] || !last_q[1]) begin
         n_bad++;
         $display("FAIL overrun_payload: got n=%0d %h %h required 2 %h %h", out_q.size(),
                  out_q.size() > 0 ? out_q[0] : 8'h00, out_q.size() > 1 ? out_q[1] : 8'h00, exp_pl[0], exp_pl[1]);
      end
   endtask

   task automatic test_random_frames();
      int         ok0, err0, l, r;
      logic [7:0] x;
      bit         to;
      for (int k = 0; k < 40; k++) begin
         tx_q.delete(); out_q.delete(); last_q.delete();
         r = $urandom_range(0, 9);
         if (k == 0) l = MAX_LEN;
         else if (k == 1) l = 1;
         else if (r == 0) l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
         else l = $urandom_range(1, MAX_LEN);
         tx_q.push_back(8'hA5);
         tx_q.push_back(8'(l));
         if (l >= 1 && l <= MAX_LEN) begin
            x = 8'(l);
            for (int i = 0; i < l; i++) begin
               tx_q.push_back(8'($urandom_range(0, 255)));
               x = x ^ tx_q[2 + i];
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            tx_q.push_back(x);
         end
         ok0 = ok_cnt; err0 = err_cnt;
         model_frame();
         send_tx(2);
         drain(exp_pl.size(), 1'b1, to);
         idle(2);
         n_cmp++;
         if (to || (ok_cnt - ok0) != int'(exp_ok) || (err_cnt - err0) != int'(!exp_ok)) begin
            n_bad++;
            $display("FAIL rand_outcome[%0d]: got oks=%0d errs=%0d timeout=%b required oks=%0d", k, ok_cnt - ok0, err_cnt - err0, to, exp_ok);
         end
         if (!exp_ok) begin
            n_cmp++;
            if (last_code !== exp_code) begin
               n_bad++; $display("FAIL rand_code[%0d]: got %0d required %0d", k, last_code, exp_code);
            end
         end
         n_cmp++;
         if (out_q.size() != exp_pl.size()) begin
            n_bad++; $display("FAIL rand_len[%0d]: got %0d required %0d", k, out_q.size(), exp_pl.size());
         end else begin
            for (int i = 0; i < exp_pl.size(); i++) begin
               n_cmp++;
               if (out_q[i] !== exp_pl[i] || last_q[i] !== (i == exp_pl.size() - 1)) begin
                  n_bad++;
                  $display("FAIL rand_byte[%0d][%0d]: got %h last=%b required %h", k, i, out_q[i], last_q[i], exp_pl[i]);
               end
            end
         end
         n_cmp++;
         if (frame_cnt !== exp_cnt) begin
            n_bad++; $display("FAIL rand_cnt[%0d]: got %0d required %0d", k, frame_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_reset_mid();
      tx_q = '{8'hA5, 8'h04, 8'h01, 8'h02};
      send_tx(0);
      rst_ni = 1'b0; #1;
      n_cmp++;
      if ({pkt_vld, frame_ok, frame_err, err_code, frame_cnt, fsm_state} !== 25'd0) begin
         n_bad++; $display("FAIL reset_mid_payload: got cnt=%0d st=%0d code=%0d required all 0", frame_cnt, fsm_state, err_code);
      end
      idle(2); rst_ni = 1'b1; exp_cnt = 16'd0; idle(1);
      pkt_rdy = 1'b0;
      tx_q = '{8'hA5, 8'h01, 8'h44, 8'h45};
      model_frame();
      send_tx(0); idle(3);
      rst_ni = 1'b0; #1;
      n_cmp++;
      if ({pkt_byte, pkt_vld, pkt_last, frame_cnt, fsm_state} !== 29'd0) begin
         n_bad++; $display("FAIL reset_mid_drain: got vld=%b byte=%h cnt=%0d st=%0d required all 0", pkt_vld, pkt_byte, frame_cnt, fsm_state);
      end
      idle(2); rst_ni = 1'b1; exp_cnt = 16'd0; pkt_rdy = 1'b1; idle(1);
   endtask

   initial begin
      idle(3);
      test_reset();
      rst_ni = 1'b1;
      idle(2);
      test_good_frame();
      test_bad_chk();
      test_good_frame();
      test_len_and_junk();
      test_timeout_parity();
      test_overrun();
      test_random_frames();
      test_reset_mid();
      test_good_frame();
      n_cmp++;
      if (both_cnt != 0) begin
         n_bad++; $display("FAIL ok_err_exclusive: got %0d overlapping cycles required 0", both_cnt);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
